// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and sizing helper for the iterative mul/div unit
package muldiv_pkg;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: conditional two's-complement negate
module muldiv_negate #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic         en,
  output logic [N-1:0] y
);
  assign y = en ? (~x + {{(N-1){1'b0}}, 1'b1}) : x;
endmodule

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative signed/unsigned shift-add multiply and restoring divide
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CW = cnt_w(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic div_q, div_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic [WIDTH-1:0] abs_a, abs_b, quo, rem, nrem;
  logic [2*WIDTH-1:0] prod, step;
  logic [WIDTH:0] msum, srem;
  logic ge, sgn_a, sgn_b;
  assign sgn_a = ~op[0] & a[WIDTH-1];
  assign sgn_b = ~op[0] & b[WIDTH-1];
  muldiv_negate #(.N(WIDTH)) u_neg_a (.x(a), .en(sgn_a), .y(abs_a));
  muldiv_negate #(.N(WIDTH)) u_neg_b (.x(b), .en(sgn_b), .y(abs_b));
  muldiv_negate #(.N(2*WIDTH)) u_neg_p (.x(acc_q), .en(sa_q ^ sb_q), .y(prod));
  muldiv_negate #(.N(WIDTH)) u_neg_q (.x(acc_q[WIDTH-1:0]), .en(sa_q ^ sb_q), .y(quo));
  muldiv_negate #(.N(WIDTH)) u_neg_r (.x(acc_q[2*WIDTH-1:WIDTH]), .en(sa_q), .y(rem));
  assign busy     = (state_q == S_RUN) || (state_q == S_FIX);
  assign done     = state_q == S_DONE;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
  always_comb begin
    msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : {(WIDTH+1){1'b0}});
    srem = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge   = srem >= {1'b0, mag_b_q};
    nrem = srem[WIDTH-1:0] - (ge ? mag_b_q : {WIDTH{1'b0}});
    step = div_q ? {nrem, acc_q[WIDTH-2:0], ge} : {msum, acc_q[WIDTH-1:1]};
  end
  always_comb begin
    state_d = state_q;
    mag_b_d = mag_b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        div_d   = op[1];
        sa_d    = sgn_a;
        sb_d    = sgn_b;
        mag_b_d = abs_b;
        acc_d   = {{WIDTH{1'b0}}, abs_a};
        cnt_d   = '0;
        dz_d    = 1'b0;
        state_d = S_RUN;
        if (op[1] && b == '0) begin
          hi_d    = a;
          lo_d    = '1;
          dz_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RUN: if (abort) state_d = S_IDLE;
      else begin
        acc_d   = step;
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(WIDTH-1)) ? S_FIX : S_RUN;
      end
      S_FIX: if (abort) state_d = S_IDLE;
      else begin
        hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
        lo_d    = div_q ? quo : prod[WIDTH-1:0];
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mag_b_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mag_b_q <= mag_b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed self-checking bench for muldiv_iter at WIDTH 32 and 8
module tb_muldiv_iter;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, abort = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0, hi, lo;
  logic busy, done, dz;
  logic start8 = 1'b0, abort8 = 1'b0;
  logic [1:0] op8 = 2'b00;
  logic [7:0] a8 = '0, b8 = '0, hi8, lo8;
  logic busy8, done8, dz8;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  muldiv_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .abort(abort),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(dz)
  );
  muldiv_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .abort(abort8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int exp_edge, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz, input int poke);
    int done_edge = -1;
    int busy_bad = 0;
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk); #1;
      if (e == 1) start = 1'b0;
      if (busy !== (e < exp_edge)) busy_bad++;
      if (done === 1'b1) begin
        done_edge = e;
        break;
      end
      if (e == poke) begin
        start = 1'b1; op = 2'b01; a = 32'd1; b = 32'd1;
      end else if (e == poke + 1) start = 1'b0;
    end
    check({tag, " done_edge"}, 64'(done_edge), 64'(exp_edge));
    check({tag, " busy"}, 64'(busy_bad), 64'd0);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, ehi});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, elo});
    check({tag, " div_zero"}, {63'd0, dz}, {63'd0, edz});
    @(posedge clk); #1;
    check({tag, " done_pulse"}, {63'd0, done}, 64'd0);
    check({tag, " hold_lo"}, {32'd0, lo}, {32'd0, elo});
  endtask
  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst hi", {32'd0, hi}, 64'd0);
    check("rst lo", {32'd0, lo}, 64'd0);
    check("rst dz", {63'd0, dz}, 64'd0);
    rst = 1'b0;
    run32("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 34, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0);
    run32("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
    run32("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
    run32("divu_zero", 2'b11, 32'd100, 32'd0, 1, 32'd100, 32'hFFFFFFFF, 1'b1, 0);
    run32("multu_small", 2'b01, 32'd2, 32'd3, 34, 32'd0, 32'd6, 1'b0, 0);
    run32("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 34, 32'd0, 32'h80000000, 1'b0, 0);
    run32("div_zero_signed", 2'b10, 32'hFFFFFFF0, 32'd0, 1, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 0);
    run32("multu_5x5", 2'b01, 32'd5, 32'd5, 34, 32'd0, 32'd25, 1'b0, 0);
    @(posedge clk); #1;
    op = 2'b11; a = 32'd9; b = 32'd2; start = 1'b1;
    seen = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (e == 1) start = 1'b0;
      if (done === 1'b1) seen++;
      if (e == 10) abort = 1'b1;
      if (e == 11) begin
        abort = 1'b0;
        check("abort busy", {63'd0, busy}, 64'd0);
      end
    end
    check("abort no_done", 64'(seen), 64'd0);
    check("abort lo", {32'd0, lo}, 64'd25);
    run32("ignored_start", 2'b11, 32'd9, 32'd2, 34, 32'd1, 32'd4, 1'b0, 3);
    @(posedge clk); #1;
    op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (e == 1) start = 1'b0;
    end
    check("pre_rst busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst busy", {63'd0, busy}, 64'd0);
    check("mid_rst done", {63'd0, done}, 64'd0);
    check("mid_rst hi", {32'd0, hi}, 64'd0);
    check("mid_rst lo", {32'd0, lo}, 64'd0);
    check("mid_rst dz", {63'd0, dz}, 64'd0);
    @(posedge clk); #1;
    op8 = 2'b10; a8 = 8'h81; b8 = 8'h0A; start8 = 1'b1;
    seen = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e == 1) start8 = 1'b0;
      if (done8 === 1'b1) begin
        seen = e;
        break;
      end
    end
    check("w8 done_edge", 64'(seen), 64'd10);
    check("w8 lo", {56'd0, lo8}, 64'hF4);
    check("w8 hi", {56'd0, hi8}, 64'hF9);
    check("w8 dz", {63'd0, dz8}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
